comp_alu_pipe: RTL

Parametrised, pipelined successor to the single-cycle CompALU. It decodes R-type instructions, reads two operands from an internal register file and executes ADD/SUB/SRL/SLL/XOR/AND/OR/SLT. Results are written back to rd, and result/zero/carry are presented on a valid/ready output port. The pipeline has two stages, one forwarding path, full backpressure and a side-band register preload port.

---
 rtl/comp_alu_pkg.sv | 56 +++++
 rtl/comp_alu_core.sv | 59 +++++
 rtl/comp_alu_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/comp_alu_pkg.sv
// Shared definitions for the pipelined CompALU: instruction field layout,
// R-type funct codes and the decoded ALU operation type.
package comp_alu_pkg;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int SH_W    = 5;

    localparam logic [5:0] OPC_RTYPE = 6'd0;

    localparam logic [5:0] FN_ADD = 6'd27;
    localparam logic [5:0] FN_SUB = 6'd28;
    localparam logic [5:0] FN_SRL = 6'd29;
    localparam logic [5:0] FN_SLL = 6'd30;
    localparam logic [5:0] FN_XOR = 6'd31;
    localparam logic [5:0] FN_AND = 6'd32;
    localparam logic [5:0] FN_OR  = 6'd33;
    localparam logic [5:0] FN_SLT = 6'd34;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SRL,
        OP_SLL,
        OP_XOR,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_ILL
    } alu_op_e;

    // Anything that is not a listed R-type funct (including the all-zero NOP) is illegal.
    function automatic alu_op_e decode_op(input logic [5:0] opcode, input logic [5:0] funct);
        alu_op_e op;
        op = OP_ILL;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FN_ADD:  op = OP_ADD;
                FN_SUB:  op = OP_SUB;
                FN_SRL:  op = OP_SRL;
                FN_SLL:  op = OP_SLL;
                FN_XOR:  op = OP_XOR;
                FN_AND:  op = OP_AND;
                FN_OR:   op = OP_OR;
                FN_SLT:  op = OP_SLT;
                default: op = OP_ILL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/comp_alu_core.sv
// Combinational DATA_W-wide ALU: result, zero, carry and illegal-op flag
// for one decoded operation.
module comp_alu_core
    import comp_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [SH_W-1:0]     shamt,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                carry,
    output logic                err
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] srl_ext;
    logic [DATA_W:0] sll_ext;

    // One guard bit beside the operand catches the last bit shifted out; shifts of
    // DATA_W or more naturally drain the result to zero.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign srl_ext = {a, 1'b0} >> shamt;
    assign sll_ext = {1'b0, a} << shamt;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a >= b);
            end
            OP_SRL: begin
                result = srl_ext[DATA_W:1];
                carry  = srl_ext[0];
            end
            OP_SLL: begin
                result = sll_ext[DATA_W-1:0];
                carry  = sll_ext[DATA_W];
            end
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: err    = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/comp_alu_pipe.sv
// Two-stage pipelined CompALU: decode/operand-read into ID, execute and
// writeback into WB which drives the valid/ready result port.
module comp_alu_pipe
    import comp_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic                out_zero,
    output logic                out_carry,
    output logic                out_err,
    input  logic                cfg_we,
    input  logic [REG_AW-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]   cfg_wdata
);

    logic [DATA_W-1:0] regs [REG_NUM];

    logic              id_valid;
    alu_op_e           id_op;
    logic [REG_AW-1:0] id_rd;
    logic [SH_W-1:0]   id_shamt;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;

    logic              wb_valid;

    logic              advance;
    logic              accept;
    logic              id_move;
    logic              id_legal;

    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_err;

    assign advance   = !wb_valid || out_ready;
    assign in_ready  = advance || !id_valid;
    assign accept    = in_valid && in_ready;
    assign id_move   = id_valid && advance;
    assign id_legal  = (id_op != OP_ILL);
    assign out_valid = wb_valid;

    assign rs_idx = in_instr[RS_LSB +: REG_AW];
    assign rt_idx = in_instr[RT_LSB +: REG_AW];

    // The instruction leaving ID writes the regfile on this same edge, so a
    // reader being accepted now must take its result straight from the ALU.
    always_comb begin
        opnd_a = regs[rs_idx];
        opnd_b = regs[rt_idx];
        if (id_move && id_legal && (id_rd == rs_idx)) opnd_a = alu_result;
        if (id_move && id_legal && (id_rd == rt_idx)) opnd_b = alu_result;
    end

    comp_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op     (id_op),
        .a      (id_a),
        .b      (id_b),
        .shamt  (id_shamt),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry),
        .err    (alu_err)
    );

    // NOTE: the regfile is a flop array with a reset because every register must read
    // as zero after reset; it cannot be mapped onto a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            if (cfg_we) regs[cfg_addr] <= cfg_wdata;
            // Later assignment wins, so a pipeline writeback overrides a same-index preload.
            if (id_move && id_legal) regs[id_rd] <= alu_result;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_op    <= OP_ADD;
            id_rd    <= '0;
            id_shamt <= '0;
            id_a     <= '0;
            id_b     <= '0;
        end else begin
            if (in_ready) id_valid <= in_valid;
            if (accept) begin
                id_op    <= decode_op(in_instr[OPC_LSB +: 6], in_instr[FN_LSB +: 6]);
                id_rd    <= in_instr[RD_LSB +: REG_AW];
                id_shamt <= in_instr[SH_LSB +: SH_W];
                id_a     <= opnd_a;
                id_b     <= opnd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
        end else if (advance) begin
            wb_valid   <= id_valid;
            out_result <= id_valid ? alu_result : '0;
            out_zero   <= id_valid & alu_zero;
            out_carry  <= id_valid & alu_carry;
            out_err    <= id_valid & alu_err;
        end
    end

endmodule
